ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single-port 8-bit RAM between the CPU memory interface and a secondary bus master (DMA/loader engine) using a request/acknowledge handshake. The CPU has fixed priority, and a starvation guard guarantees the secondary master a slot after a bounded number of consecutive CPU grants. The block sits between the CPU's memory-address/MDR logic and `u_ram`, and gives every access a fixed two-cycle latency so the CPU microcode can count cycles deterministically.

## Interface

- `ADDR_WIDTH`, default 16: address width of both requesters and the RAM port.
- `DATA_WIDTH`, default 8: data width.
- `STARVE_LIMIT`, default 4: consecutive CPU grants allowed while the DMA master is waiting before the DMA master is forced in. Legal range is 1..15.

Ports:

- `clk` input 1: system clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `cpu_req` input 1: CPU access request; held high until `cpu_ack`.
- `cpu_we` input 1: 1 means write, 0 means read.
- `cpu_addr` input ADDR_WIDTH: CPU address.
- `cpu_wdata` input DATA_WIDTH: CPU write data.
- `cpu_ack` output 1: one-cycle completion pulse.
- `cpu_rdata` output DATA_WIDTH: read data; valid while `cpu_ack` is high, held afterwards.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`: same meaning as the CPU signals, for the DMA master.
- `ram_addr` output ADDR_WIDTH: RAM address.
- `ram_we` output 1: RAM write strobe.
- `ram_wdata` output DATA_WIDTH: RAM write data.
- `ram_rdata` input DATA_WIDTH: synchronous RAM read data, valid one cycle after the address is presented.
- `dma_grant` output 1: high during a DMA access (ACC or DONE state), for debug and bench observation.

## Operation

States: `IDLE`, `CPU_ACC`, `CPU_DONE`, `DMA_ACC`, `DMA_DONE`.

In `IDLE`, requests are sampled; the chosen request's `we`, `addr` and `wdata` are latched.
- Only `cpu_req` is high: go to `CPU_ACC`.
- Only `dma_req` is high: go to `DMA_ACC`.
- Both are high: go to `CPU_ACC` unless `streak == STARVE_LIMIT`, in which case go to `DMA_ACC`.
- Neither is high: stay in `IDLE`.

In `*_ACC`:
- Drive `ram_addr` and `ram_wdata` from the latched values.
- Drive `ram_we` equal to the latched `we`.
- Go to `*_DONE` unconditionally.

In `*_DONE`:
- Pulse the matching ack.
- Capture `ram_rdata` into the matching rdata register. On writes, the rdata register is left unchanged.
- `ram_we` is 0.
- Go to `IDLE` unconditionally.

Starvation counter `streak` (4 bits):
- On a CPU grant while `dma_req` is high: increment, saturating at `STARVE_LIMIT`.
- On a DMA grant: clear.
- In `IDLE` with `dma_req` low: clear.

Requester rules:
- Requesters do not change `we`/`addr`/`wdata` while `req` is high and the ack has not yet arrived. The arbiter uses latched copies regardless.
- A request seen in `IDLE` the cycle after an ack is a new transaction. A requester that holds `req` through its ack gets a second access.

Reset:
- Synchronous; overrides everything, including mid-access.
- State goes to `IDLE`, `streak` to 0.
- All outputs go to 0: `cpu_ack`, `dma_ack`, `cpu_rdata`, `dma_rdata`, `ram_addr`, `ram_we`, `ram_wdata`, `dma_grant`.
- An in-flight access is dropped with no ack. A write issued in `*_ACC` before the reset edge has already completed in RAM.

`ram_we` is never high outside `*_ACC`, and never high for more than one cycle per transaction.

## Timing

- Request high at edge N in `IDLE`:
  - ACC state in cycle N+1, with the RAM strobes driven.
  - DONE state in cycle N+2, with the ack high and rdata valid.
  - Back in `IDLE` at N+3.
- Throughput: one access per 3 cycles per arbiter, for either master.
- Back-to-back CPU accesses with `dma_req` held: the DMA master is granted at most `STARVE_LIMIT` × 3 + 3 cycles after `dma_req` rises.
- Simultaneous `cpu_req` rise and `reset`: reset wins, and the request is resampled in `IDLE` after reset deasserts.
- Acks are registered outputs, never combinational from `req`.

## Test plan

- **Reset values:** assert `reset` for 2 cycles with both requests high -> all outputs are 0, and the first grant occurs no earlier than 1 cycle after `reset` falls.
- **CPU write then read:**
  - CPU write: addr `16'h0010`, data `8'h05`. Expect `ram_we` for exactly one cycle, and `cpu_ack` 2 cycles after the request edge.
  - CPU read of `16'h0010`: expect `cpu_rdata == 8'h05` together with `cpu_ack`, and `dma_ack` stays 0 throughout.
- **Simultaneous requests (`STARVE_LIMIT=4`, `streak` 0):**
  - Both masters request at once: the CPU is served first, `dma_grant` stays low.
  - The DMA master is served in the next slot once the CPU drops `cpu_req`.
- **Starvation guard:**
  - Stimulus: `cpu_req` held high continuously; `dma_req` raised and held with a read of `16'h0020`.
  - Required response: exactly 4 CPU acks, then `dma_ack` with the correct data, then CPU acks resume.
- **Mid-access reset:**
  - Assert `reset` in `DMA_ACC` of a DMA read: no `dma_ack` is ever produced, and the state is `IDLE` the cycle after reset.
  - Then a CPU read of `16'h0010` completes normally with `8'h05`.
- **Held request:** CPU holds `cpu_req` through its ack for a read of `16'hF004` -> a second access starts in the cycle after returning to `IDLE`, and the two `cpu_ack` pulses are exactly 3 cycles apart.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// ============================================================================
// Module      : ram_port_arbiter_if
// Description : Bundles the two requester handshakes (CPU and DMA) with the
//               single-port RAM bus that the arbiter shares between them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_ack;
    logic [DATA_WIDTH-1:0] dma_rdata;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  dma_grant;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output dma_grant
    );

    // Requesters plus the RAM itself
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  dma_grant
    );
endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module      : ram_port_arbiter
// Description : Fixed-priority CPU/DMA arbiter for a single-port synchronous
//               RAM with a starvation guard and a fixed two-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    ram_port_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_ACC  = 3'd1,
        S_CPU_DONE = 3'd2,
        S_DMA_ACC  = 3'd3,
        S_DMA_DONE = 3'd4
    } state_t;

    localparam logic [3:0] c_streak_max = 4'(STARVE_LIMIT);

    state_t                state_q;
    logic [3:0]            streak_q;
    logic                  cpu_ack_q;
    logic                  dma_ack_q;
    logic                  dma_grant_q;
    logic                  ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] dma_rdata_q;
    logic                  cpu_fwd_q;
    logic                  dma_fwd_q;

    logic                  w_dma_starved;

    assign w_dma_starved = bus.dma_req && (streak_q == c_streak_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            streak_q    <= 4'd0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            dma_grant_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_fwd_q   <= 1'b0;
            dma_fwd_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            cpu_fwd_q <= 1'b0;
            dma_fwd_q <= 1'b0;

            // The read data forwarded during DONE is frozen at the end of DONE
            if (cpu_fwd_q) cpu_rdata_q <= bus.ram_rdata;
            if (dma_fwd_q) dma_rdata_q <= bus.ram_rdata;

            case (state_q)
                S_IDLE: begin
                    if (bus.cpu_req && !w_dma_starved) begin
                        state_q     <= S_CPU_ACC;
                        ram_addr_q  <= bus.cpu_addr;
                        ram_wdata_q <= bus.cpu_wdata;
                        ram_we_q    <= bus.cpu_we;
                        if (!bus.dma_req)
                            streak_q <= 4'd0;
                        else if (streak_q < c_streak_max)
                            streak_q <= streak_q + 4'd1;
                    end else if (bus.dma_req) begin
                        state_q     <= S_DMA_ACC;
                        ram_addr_q  <= bus.dma_addr;
                        ram_wdata_q <= bus.dma_wdata;
                        ram_we_q    <= bus.dma_we;
                        dma_grant_q <= 1'b1;
                        streak_q    <= 4'd0;
                    end else begin
                        streak_q    <= 4'd0;
                    end
                end
                S_CPU_ACC: begin
                    state_q   <= S_CPU_DONE;
                    ram_we_q  <= 1'b0;
                    cpu_ack_q <= 1'b1;
                    cpu_fwd_q <= !ram_we_q;
                end
                S_CPU_DONE: begin
                    state_q <= S_IDLE;
                end
                S_DMA_ACC: begin
                    state_q   <= S_DMA_DONE;
                    ram_we_q  <= 1'b0;
                    dma_ack_q <= 1'b1;
                    dma_fwd_q <= !ram_we_q;
                end
                S_DMA_DONE: begin
                    state_q     <= S_IDLE;
                    dma_grant_q <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    ram_we_q    <= 1'b0;
                    dma_grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_grant = dma_grant_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    // RAM data lands in DONE, so it is passed straight through alongside the ack
    assign bus.cpu_rdata = cpu_fwd_q ? bus.ram_rdata : cpu_rdata_q;
    assign bus.dma_rdata = dma_fwd_q ? bus.ram_rdata : dma_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter with a behavioural
//               synchronous RAM and per-requester read-data scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] cpu_sb[$];
    logic [DW-1:0] dma_sb[$];
    logic [DW-1:0] cpu_last = '0;
    logic [DW-1:0] dma_last = '0;
    logic [DW-1:0] cpu_hold = '0;
    logic [DW-1:0] dma_hold = '0;
    bit cpu_hold_chk = 0;
    bit dma_hold_chk = 0;
    bit we_prev      = 0;

    // Synchronous single-port RAM: data appears the cycle after the address
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every ack pops one expected value
    always @(negedge clk) begin
        if (rst) begin
            cpu_hold_chk = 0;
            dma_hold_chk = 0;
            we_prev      = 0;
        end else begin
            if (bus.cpu_ack) begin
                vectors++;
                if (cpu_sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL cpu_ack_unexpected: cyc %0d rdata %h, no access outstanding", cyc, bus.cpu_rdata);
                end else begin
                    cpu_hold = cpu_sb.pop_front();
                    if (bus.cpu_rdata !== cpu_hold) begin
                        miscompares++;
                        $display("FAIL cpu_rdata: cyc %0d got %h expected %h", cyc, bus.cpu_rdata, cpu_hold);
                    end
                    cpu_hold_chk = 1;
                end
            end else if (cpu_hold_chk) begin
                vectors++;
                if (bus.cpu_rdata !== cpu_hold) begin
                    miscompares++;
                    $display("FAIL cpu_rdata_hold: cyc %0d got %h expected %h", cyc, bus.cpu_rdata, cpu_hold);
                end
                cpu_hold_chk = 0;
            end
            if (bus.dma_ack) begin
                vectors++;
                if (dma_sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL dma_ack_unexpected: cyc %0d rdata %h, no access outstanding", cyc, bus.dma_rdata);
                end else begin
                    dma_hold = dma_sb.pop_front();
                    if (bus.dma_rdata !== dma_hold) begin
                        miscompares++;
                        $display("FAIL dma_rdata: cyc %0d got %h expected %h", cyc, bus.dma_rdata, dma_hold);
                    end
                    dma_hold_chk = 1;
                end
            end else if (dma_hold_chk) begin
                vectors++;
                if (bus.dma_rdata !== dma_hold) begin
                    miscompares++;
                    $display("FAIL dma_rdata_hold: cyc %0d got %h expected %h", cyc, bus.dma_rdata, dma_hold);
                end
                dma_hold_chk = 0;
            end
            if (bus.ram_we && we_prev) begin
                miscompares++;
                $display("FAIL ram_we_width: cyc %0d ram_we high 2 cycles running, expected 1", cyc);
            end
            if (bus.cpu_ack && bus.dma_ack) begin
                miscompares++;
                $display("FAIL dual_ack: cyc %0d cpu_ack=1 dma_ack=1, expected at most one", cyc);
            end
            we_prev = bus.ram_we;
        end
    end

    task automatic wait_cpu_ack(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cpu_ack_timeout: got no ack in 40 cycles, expected one");
        end
    endtask

    task automatic wait_dma_ack(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.dma_ack) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dma_ack_timeout: got no ack in 40 cycles, expected one");
        end
    endtask

    task automatic test_reset;
        int e, c;
        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 8'h00;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0020; bus.dma_wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.cpu_ack, bus.dma_ack, bus.cpu_rdata, bus.dma_rdata, bus.ram_addr,
             bus.ram_we, bus.ram_wdata, bus.dma_grant} !== 44'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack %b/%b rdata %h/%h addr %h we %b wdata %h grant %b, expected all 0",
                     bus.cpu_ack, bus.dma_ack, bus.cpu_rdata, bus.dma_rdata, bus.ram_addr,
                     bus.ram_we, bus.ram_wdata, bus.dma_grant);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        e = cyc + 1;
        cpu_last = ref_mem[16'h0030]; cpu_sb.push_back(cpu_last);
        dma_last = ref_mem[16'h0020]; dma_sb.push_back(dma_last);
        @(negedge clk);
        vectors++;
        if (bus.ram_addr !== 16'h0 || bus.dma_grant !== 1'b0 || bus.cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_early_grant: addr %h grant %b ack %b in release cycle, expected 0/0/0",
                     bus.ram_addr, bus.dma_grant, bus.cpu_ack);
        end
        wait_cpu_ack(c);
        bus.cpu_req = 1'b0;
        vectors++;
        if (c != e + 1) begin
            miscompares++;
            $display("FAIL reset_first_cpu_ack: ack at cyc %0d expected %0d", c, e + 1);
        end
        wait_dma_ack(c);
        bus.dma_req = 1'b0;
        vectors++;
        if (c != e + 4) begin
            miscompares++;
            $display("FAIL reset_dma_after_cpu: ack at cyc %0d expected %0d", c, e + 4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_write;
        int e, c, we_cnt;
        bit bad_strobe;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h05;
        ref_mem[16'h0010] = 8'h05;
        cpu_sb.push_back(cpu_last);
        e = cyc + 1; c = -1; we_cnt = 0; bad_strobe = 0;
        for (int i = 0; i < 20 && c < 0; i++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                we_cnt++;
                if (bus.ram_addr !== 16'h0010 || bus.ram_wdata !== 8'h05) bad_strobe = 1;
            end
            if (bus.cpu_ack) c = cyc;
        end
        bus.cpu_req = 1'b0;
        vectors++;
        if (c != e + 1) begin
            miscompares++;
            $display("FAIL write_ack_latency: ack at cyc %0d expected %0d", c, e + 1);
        end
        vectors++;
        if (we_cnt != 1 || bad_strobe) begin
            miscompares++;
            $display("FAIL write_strobe: %0d strobe cycles (bad addr/data=%b), expected 1 cycle at 0010/05", we_cnt, bad_strobe);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read;
        int e, c, dma_seen;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'hEE;
        cpu_last = ref_mem[16'h0010]; cpu_sb.push_back(cpu_last);
        e = cyc + 1; c = -1; dma_seen = 0;
        for (int i = 0; i < 20 && c < 0; i++) begin
            @(negedge clk);
            if (bus.dma_ack) dma_seen++;
            if (bus.cpu_ack) c = cyc;
        end
        bus.cpu_req = 1'b0;
        vectors++;
        if (c != e + 1) begin
            miscompares++;
            $display("FAIL read_ack_latency: ack at cyc %0d expected %0d", c, e + 1);
        end
        vectors++;
        if (dma_seen != 0) begin
            miscompares++;
            $display("FAIL read_dma_ack: saw %0d dma_ack pulses, expected 0", dma_seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous;
        int e, c, grant_seen;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0020;
        cpu_last = ref_mem[16'h0010]; cpu_sb.push_back(cpu_last);
        dma_last = ref_mem[16'h0020]; dma_sb.push_back(dma_last);
        e = cyc + 1; c = -1; grant_seen = 0;
        for (int i = 0; i < 20 && c < 0; i++) begin
            @(negedge clk);
            if (bus.dma_grant) grant_seen++;
            if (bus.cpu_ack) c = cyc;
        end
        bus.cpu_req = 1'b0;
        vectors++;
        if (c != e + 1 || grant_seen != 0) begin
            miscompares++;
            $display("FAIL simul_cpu_first: cpu ack cyc %0d grant cycles %0d, expected cyc %0d and 0", c, grant_seen, e + 1);
        end
        wait_dma_ack(c);
        bus.dma_req = 1'b0;
        vectors++;
        if (c != e + 4) begin
            miscompares++;
            $display("FAIL simul_dma_next_slot: ack at cyc %0d expected %0d", c, e + 4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_starvation;
        int e, first_grant, cpu_cnt, cpu_before;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0020;
        cpu_last = ref_mem[16'h0040];
        for (int i = 0; i < 6; i++) cpu_sb.push_back(cpu_last);
        dma_last = ref_mem[16'h0020]; dma_sb.push_back(dma_last);
        e = cyc + 1; first_grant = -1; cpu_cnt = 0; cpu_before = -1;
        for (int i = 0; i < 80 && cpu_cnt < 6; i++) begin
            @(negedge clk);
            if (bus.dma_grant && first_grant < 0) first_grant = cyc;
            if (bus.dma_ack) begin
                cpu_before = cpu_cnt;
                bus.dma_req = 1'b0;
            end
            if (bus.cpu_ack) begin
                cpu_cnt++;
                if (cpu_cnt == 6) bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        vectors++;
        if (cpu_before != 4) begin
            miscompares++;
            $display("FAIL starve_cpu_count: %0d cpu acks before dma_ack, expected 4", cpu_before);
        end
        vectors++;
        if (first_grant != e + 12) begin
            miscompares++;
            $display("FAIL starve_grant_time: dma_grant at cyc %0d expected %0d", first_grant, e + 12);
        end
        vectors++;
        if (cpu_cnt != 6) begin
            miscompares++;
            $display("FAIL starve_cpu_resume: %0d cpu acks total, expected 6", cpu_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        int e, c, dma_seen;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0020;
        dma_sb.push_back(ref_mem[16'h0020]);
        e = cyc + 1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.dma_grant !== 1'b1 || cyc != e) begin
            miscompares++;
            $display("FAIL midreset_in_acc: grant %b at cyc %0d, expected 1 at cyc %0d", bus.dma_grant, cyc, e);
        end
        rst = 1'b1;
        bus.dma_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        dma_sb.delete();
        dma_last = '0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        cpu_last = ref_mem[16'h0010]; cpu_sb.push_back(cpu_last);
        e = cyc + 1; c = -1; dma_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.dma_ack || bus.dma_grant) dma_seen++;
            if (bus.cpu_ack && c < 0) begin
                c = cyc;
                bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        vectors++;
        if (dma_seen != 0 || bus.dma_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_dma_dropped: %0d dma ack/grant cycles, dma_rdata %h, expected 0 and 00", dma_seen, bus.dma_rdata);
        end
        vectors++;
        if (c != e + 1) begin
            miscompares++;
            $display("FAIL midreset_cpu_read: ack at cyc %0d expected %0d", c, e + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_held_request;
        int e, a1, a2;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hF004;
        cpu_last = ref_mem[16'hF004];
        cpu_sb.push_back(cpu_last);
        cpu_sb.push_back(cpu_last);
        e = cyc + 1;
        wait_cpu_ack(a1);
        wait_cpu_ack(a2);
        bus.cpu_req = 1'b0;
        vectors++;
        if (a1 != e + 1 || a2 - a1 != 3) begin
            miscompares++;
            $display("FAIL held_back_to_back: acks at cyc %0d and %0d, expected %0d and %0d", a1, a2, e + 1, e + 4);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem[16'h0020] = 8'h3C; ref_mem[16'h0020] = 8'h3C;
        mem[16'h0030] = 8'h11; ref_mem[16'h0030] = 8'h11;
        mem[16'h0040] = 8'h77; ref_mem[16'h0040] = 8'h77;
        mem[16'hF004] = 8'hA5; ref_mem[16'hF004] = 8'hA5;

        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_mid_reset();
        test_held_request();

        repeat (4) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (cpu_sb.size() != 0 || dma_sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d cpu and %0d dma accesses never acked, expected 0 and 0",
                     cpu_sb.size(), dma_sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
